seq_det_prog: RTL and testbench

Programmable, parametrised Moore sequence detector. It is the next generation of the fixed-pattern detector used in the design. It matches a serial bit stream against a run-time-loadable pattern of 1..PAT_W bits, with selectable overlapping or non-overlapping detection, input qualification and an optional saturating match counter. It sits between a serial front end and control logic that needs a registered "pattern seen" flag.

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/seq_det_hist.sv | 38 +++
 rtl/seq_det_prog.sv | 130 +++++++++++++
 tb/tb_seq_det_prog.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
// Optional match counter is enabled by defining SEQ_DET_CNT_EN.
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_DIS  = 2'd0,
    S_FILL = 2'd1,
    S_HUNT = 2'd2,
    S_HIT  = 2'd3
  } state_e;

  // Bits needed to hold a length in the range 0..pat_w.
  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register plus saturating fill counter for seq_det_prog.
// Exposes the post-shift values so the top can compare against the bit being accepted.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  localparam int LEN_W = len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             fill_zero,
  input  logic             din,
  output logic [PAT_W-1:0] hist_next,
  output logic [LEN_W-1:0] fill_next
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] hist_q;
  logic [LEN_W-1:0] fill_q;

  // Oldest bit falls off the top; newest bit enters at bit 0.
  assign hist_next = (hist_q << 1) | PAT_W'(din);
  assign fill_next = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift) begin
      hist_q <= hist_next;
      fill_q <= fill_zero ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable Moore sequence detector with run-time pattern, length and overlap mode.
// Define SEQ_DET_CNT_EN to add the saturating match counter (match_cnt, cnt_clr).
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b0110),
  parameter int              DEF_LEN = PAT_W,
  parameter bit              DEF_OVL = 1'b1,
  parameter int              CNT_W   = 8,
  localparam int             LEN_W   = len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  // Stream handshake: in is consumed on every clk edge where in_valid is high
  // and cfg_load is low; there is no back-pressure.
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             out,
  output logic [1:0]       dbg_state
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             cnt_clr
`endif
);

  localparam logic [LEN_W-1:0] DEF_LEN_C = LEN_W'(clamp_len(DEF_LEN, PAT_W));
  localparam state_e           DEF_STATE = (DEF_LEN == 0) ? S_DIS : S_FILL;
  localparam logic [PAT_W:0]   ONE       = (PAT_W+1)'(1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;

  logic [LEN_W-1:0] len_c;
  logic [PAT_W-1:0] hist_next;
  logic [LEN_W-1:0] fill_next;
  logic [PAT_W:0]   mask_full;
  logic [PAT_W-1:0] len_mask;
  logic             accept;
  logic             hit;
  logic             fill_zero;

  assign len_c  = LEN_W'(clamp_len(32'(cfg_len), PAT_W));
  assign accept = in_valid && !cfg_load;

  // One extra bit so that len == PAT_W yields an all-ones mask.
  assign mask_full = (ONE << len_q) - ONE;
  assign len_mask  = mask_full[PAT_W-1:0];

  assign hit = (len_q != '0) && (fill_next >= len_q) &&
               (((hist_next ^ pat_q) & len_mask) == '0);

  // Non-overlapping mode consumes the matched bits.
  assign fill_zero = hit && !ovl_q;

  seq_det_hist #(
    .PAT_W(PAT_W)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .clr      (cfg_load),
    .shift    (accept),
    .fill_zero(fill_zero),
    .din      (in),
    .hist_next(hist_next),
    .fill_next(fill_next)
  );

  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = (len_c == '0) ? S_DIS : S_FILL;
    end else if (in_valid) begin
      if (len_q == '0)
        state_d = S_DIS;
      else if (hit)
        state_d = S_HIT;
      else if (fill_next < len_q)
        state_d = S_FILL;
      else
        state_d = S_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= DEF_PAT;
      len_q   <= DEF_LEN_C;
      ovl_q   <= DEF_OVL;
      state_q <= DEF_STATE;
    end else begin
      if (cfg_load) begin
        pat_q <= cfg_pattern;
        len_q <= len_c;
        ovl_q <= cfg_overlap;
      end
      state_q <= state_d;
    end
  end

  assign out       = (state_q == S_HIT);
  assign dbg_state = state_q;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             hit_evt;

  assign hit_evt = accept && hit;

  // A clear coinciding with a hit leaves the count at one.
  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (cnt_clr)
      cnt_q <= hit_evt ? CNT_W'(1) : '0;
    else if (hit_evt && (cnt_q != '1))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog: directed scenarios plus randomized traffic
// against a queue-based reference model. Counter checks apply when SEQ_DET_CNT_EN is defined.
module tb_seq_det_prog;
  import seq_det_pkg::*;

  localparam int PAT_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       cfg_overlap;
  logic       out;
  logic [1:0] dbg_state;
`ifdef SEQ_DET_CNT_EN
  logic [1:0] match_cnt;
  logic       cnt_clr;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: accepted bits since the last clear, and how many may start a match.
  bit         hq[$];
  int         m_since;
  logic [3:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_out;
  int         m_cnt;

  seq_det_prog #(
    .PAT_W  (PAT_W),
    .DEF_PAT(4'b0110),
    .DEF_LEN(4),
    .DEF_OVL(1'b1),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in         (in_bit),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .out        (out),
    .dbg_state  (dbg_state)
`ifdef SEQ_DET_CNT_EN
    ,
    .match_cnt  (match_cnt),
    .cnt_clr    (cnt_clr)
`endif
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    hq.delete();
    m_since = 0;
    m_pat   = 4'b0110;
    m_len   = 4;
    m_ovl   = 1'b1;
    m_out   = 1'b0;
    m_cnt   = 0;
  endfunction

  function automatic void model_step(input bit v, input bit b, input bit ld, input bit clr);
    bit hit_ev;
    bit ok;
    hit_ev = 1'b0;
    if (ld) begin
      m_pat = cfg_pattern;
      m_len = (int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len);
      m_ovl = cfg_overlap;
      hq.delete();
      m_since = 0;
      m_out = 1'b0;
    end else if (v) begin
      hq.push_back(b);
      if (hq.size() > PAT_W) void'(hq.pop_front());
      if (m_since < PAT_W) m_since++;
      ok = (m_len > 0) && (m_since >= m_len);
      // Pattern bit i must equal the bit received i steps ago.
      for (int i = 0; ok && i < m_len; i++)
        if (hq[hq.size() - 1 - i] != m_pat[i]) ok = 1'b0;
      if (ok && !m_ovl) m_since = 0;
      m_out  = ok;
      hit_ev = ok;
    end
    if (clr) m_cnt = hit_ev ? 1 : 0;
    else if (hit_ev && m_cnt < CNT_MAX) m_cnt++;
  endfunction

  task automatic drive(input bit v, input bit b, input bit ld, input bit clr);
    in_valid = v;
    in_bit   = b;
    cfg_load = ld;
`ifdef SEQ_DET_CNT_EN
    cnt_clr  = clr;
`endif
    model_step(v, b, ld, clr);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
`ifdef SEQ_DET_CNT_EN
    cnt_clr  = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_cfg(input logic [3:0] p, input logic [2:0] l, input bit o);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
  endtask

  task automatic test_reset();
    in_valid = 0; in_bit = 0; cfg_load = 0;
`ifdef SEQ_DET_CNT_EN
    cnt_clr = 0;
`endif
    set_cfg(4'b0000, 3'd0, 1'b0);
    do_reset();
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL reset_out got=%b exp=0", out); end
    checks++;
    if (dbg_state !== S_FILL) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_FILL); end
`ifdef SEQ_DET_CNT_EN
    checks++;
    if (match_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", match_cnt); end
`endif
  endtask

  task automatic test_default_stream();
    logic [6:0] s = 7'b0110110;
    logic [6:0] e = 7'b0001001;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s[6-i], 1'b0, 1'b0);
      checks++;
      if (out !== e[6-i]) begin errors++; $display("FAIL default_out bit%0d got=%b exp=%b", i+1, out, e[6-i]); end
    end
`ifdef SEQ_DET_CNT_EN
    checks++;
    if (match_cnt !== 2'd2) begin errors++; $display("FAIL default_cnt got=%0d exp=2", match_cnt); end
`endif
  endtask

  task automatic test_nonoverlap();
    logic [6:0] s = 7'b0110110;
    logic [6:0] e = 7'b0001000;
    set_cfg(4'b0110, 3'd4, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL nonovl_load_out got=%b exp=0", out); end
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s[6-i], 1'b0, 1'b0);
      checks++;
      if (out !== e[6-i]) begin errors++; $display("FAIL nonovl_out bit%0d got=%b exp=%b", i+1, out, e[6-i]); end
    end
`ifdef SEQ_DET_CNT_EN
    checks++;
    if (match_cnt !== 2'd1) begin errors++; $display("FAIL nonovl_cnt got=%0d exp=1", match_cnt); end
`endif
  endtask

  task automatic test_overlap_11();
    logic [3:0] e_ovl = 4'b0111;
    logic [3:0] e_non = 4'b0101;
    set_cfg(4'b0011, 3'd2, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (out !== e_ovl[3-i]) begin errors++; $display("FAIL ovl11_out bit%0d got=%b exp=%b", i+1, out, e_ovl[3-i]); end
    end
`ifdef SEQ_DET_CNT_EN
    checks++;
    if (match_cnt !== 2'd3) begin errors++; $display("FAIL ovl11_cnt got=%0d exp=3", match_cnt); end
`endif
    set_cfg(4'b0011, 3'd2, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (out !== e_non[3-i]) begin errors++; $display("FAIL non11_out bit%0d got=%b exp=%b", i+1, out, e_non[3-i]); end
    end
`ifdef SEQ_DET_CNT_EN
    checks++;
    if (match_cnt !== 2'd2) begin errors++; $display("FAIL non11_cnt got=%0d exp=2", match_cnt); end
`endif
  endtask

  task automatic test_gap();
    logic [2:0] s = 3'b011;
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, s[2-i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (out !== 1'b0) begin errors++; $display("FAIL gap_pre_out cyc%0d got=%b exp=0", i, out); end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL gap_hit_out got=%b exp=1", out); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (out !== 1'b1) begin errors++; $display("FAIL gap_hold_out cyc%0d got=%b exp=1", i, out); end
    end
  endtask

  task automatic test_load_discard();
    logic [2:0] s = 3'b011;
    logic [2:0] t = 3'b110;
    logic [2:0] e = 3'b001;
    do_reset();
    set_cfg(4'b0110, 3'd4, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, s[2-i], 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL discard_load_out got=%b exp=0", out); end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL discard_after_out got=%b exp=0", out); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, t[2-i], 1'b0, 1'b0);
      checks++;
      if (out !== e[2-i]) begin errors++; $display("FAIL discard_refill_out bit%0d got=%b exp=%b", i, out, e[2-i]); end
    end
  endtask

  task automatic test_saturation();
    logic [6:0] e = 7'b0111111;
    do_reset();
    set_cfg(4'b0011, 3'd2, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (out !== e[6-i]) begin errors++; $display("FAIL sat_out bit%0d got=%b exp=%b", i+1, out, e[6-i]); end
    end
`ifdef SEQ_DET_CNT_EN
    checks++;
    if (match_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt got=%0d exp=3", match_cnt); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (match_cnt !== 2'd0) begin errors++; $display("FAIL sat_clr got=%0d exp=0", match_cnt); end
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (match_cnt !== 2'd1) begin errors++; $display("FAIL clr_with_hit got=%0d exp=1", match_cnt); end
`endif
    set_cfg(4'b0011, 3'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      checks++;
      if (out !== 1'b0) begin errors++; $display("FAIL len0_out bit%0d got=%b exp=0", i, out); end
    end
    checks++;
    if (dbg_state !== S_DIS) begin errors++; $display("FAIL len0_state got=%0d exp=%0d", dbg_state, S_DIS); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] s = 4'b0110;
    logic [3:0] e = 4'b0001;
    set_cfg(4'b0101, 3'd3, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s[3-i], 1'b0, 1'b0);
      checks++;
      if (out !== e[3-i]) begin errors++; $display("FAIL rstmid_out bit%0d got=%b exp=%b", i+1, out, e[3-i]); end
    end
  endtask

  task automatic test_random();
    int r;
    bit v, b, ld, clr;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r   = $urandom_range(0, 99);
      ld  = (r < 4);
      clr = (r >= 4 && r < 8);
      v   = ($urandom_range(0, 3) != 0);
      b   = 1'($urandom_range(0, 1));
      if (ld) set_cfg(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      drive(v, b, ld, clr);
      checks++;
      if (out !== m_out) begin errors++; $display("FAIL rand_out cyc%0d got=%b exp=%b", n, out, m_out); end
`ifdef SEQ_DET_CNT_EN
      checks++;
      if (match_cnt !== 2'(m_cnt)) begin errors++; $display("FAIL rand_cnt cyc%0d got=%0d exp=%0d", n, match_cnt, m_cnt); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_default_stream();
    test_nonoverlap();
    test_overlap_11();
    test_gap();
    test_load_discard();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
